// File: rtl/swn_if.sv
// Flit bus of the swn switch: flat input/output flit vectors plus per-input full flags and drop count.
interface swn_if #(
   parameter int N = 4,
   parameter int W = 10
);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_full;
   logic [N*W-1:0] out_data;
   logic [15:0]    drop_cnt;

   modport master (output in_data, input in_full, out_data, drop_cnt);
   modport slave  (input in_data, output in_full, out_data, drop_cnt);
endinterface

// File: rtl/swn.sv
// N x N input-buffered flit switch: one FIFO per input, round-robin arbiter per output,
// registered outputs, saturating count of flits dropped at full FIFOs.
module swn #(
   parameter int N     = 4,
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   swn_if.slave bus
);
   localparam int L  = $clog2(N);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [N][DEPTH];
   logic [W-1:0]  mem_d [N][DEPTH];
   logic [PW-1:0] wr_ptr_q [N], wr_ptr_d [N];
   logic [PW-1:0] rd_ptr_q [N], rd_ptr_d [N];
   logic [CW-1:0] cnt_q [N], cnt_d [N];
   logic [L-1:0]  rr_q [N], rr_d [N];
   logic [W-1:0]  out_q [N], out_d [N];
   logic [15:0]   drop_q, drop_d;

   logic [W-1:0]  in_flit [N];
   logic [W-1:0]  head [N];
   logic [N-1:0]  full, push, pop, drop;
   logic [N-1:0]  gnt_valid;
   logic [L-1:0]  gnt_idx [N];
   logic [L-1:0]  cand;
   logic [4:0]    drop_n;
   logic [16:0]   drop_sum;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_flit[i] = bus.in_data[i*W +: W];
         head[i]    = mem_q[i][rd_ptr_q[i]];
         full[i]    = (cnt_q[i] == CW'(DEPTH));
         // A full FIFO refuses the arrival even if it is popped in the same cycle.
         push[i]    = in_flit[i][W-1] & ~full[i];
         drop[i]    = in_flit[i][W-1] & full[i];
      end
   end

   // Each output scans inputs starting at its priority pointer; the first head aimed at it wins.
   always_comb begin
      gnt_valid = '0;
      pop       = '0;
      cand      = '0;
      for (int o = 0; o < N; o++) begin
         gnt_idx[o] = '0;
         for (int k = 0; k < N; k++) begin
            cand = rr_q[o] + L'(k);
            if (!gnt_valid[o] && (cnt_q[cand] != '0) && (head[cand][L-1:0] == L'(o))) begin
               gnt_valid[o] = 1'b1;
               gnt_idx[o]   = cand;
            end
         end
      end
      for (int o = 0; o < N; o++) begin
         if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < N; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = in_flit[i];
            wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
         end
         if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      for (int o = 0; o < N; o++) begin
         out_d[o] = gnt_valid[o] ? head[gnt_idx[o]] : '0;
         rr_d[o]  = gnt_valid[o] ? gnt_idx[o] + L'(1) : rr_q[o];
      end
      drop_n = '0;
      for (int i = 0; i < N; i++) drop_n = drop_n + 5'(drop[i]);
      drop_sum = {1'b0, drop_q} + 17'(drop_n);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Storage needs no reset: emptied pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            rr_q[i]     <= '0;
            out_q[i]    <= '0;
         end
         drop_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
            rr_q[i]     <= rr_d[i];
            out_q[i]    <= out_d[i];
         end
         drop_q <= drop_d;
      end
   end

   always_comb begin
      bus.out_data = '0;
      for (int o = 0; o < N; o++) bus.out_data[o*W +: W] = out_q[o];
   end

   assign bus.in_full  = full;
   assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_swn.sv
// Bench for swn: queue-based reference switch checked every cycle, plus literal pins for key scenarios.
module tb_swn;
   localparam int N     = 4;
   localparam int W     = 10;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           chk_en = 1'b0;
   logic [N*W-1:0] drv;
   int             n_chk  = 0;
   int             n_fail = 0;

   swn_if #(.N(N), .W(W)) bus ();
   assign bus.in_data = drv;

   swn #(.N(N), .W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference model state
   logic [W-1:0] fifo_q [N][$];
   int           rr [N];
   logic [W-1:0] exp_out [N];
   int           exp_drop;
   logic [W-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] put(input int port, input logic [W-1:0] f);
      logic [N*W-1:0] r;
      r = '0;
      r[port*W +: W] = f;
      return r;
   endfunction

   task automatic cyc(input logic [N*W-1:0] v);
      drv = v;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc('0);
   endtask

   always @(posedge clk) begin : model
      int gsrc [N];
      int g;
      logic [N-1:0] was_full;
      logic [W-1:0] f;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            fifo_q[i].delete();
            rr[i]      = 0;
            exp_out[i] = '0;
         end
         exp_drop = 0;
      end else begin
         for (int i = 0; i < N; i++) was_full[i] = (fifo_q[i].size() == DEPTH);
         for (int o = 0; o < N; o++) begin
            gsrc[o] = -1;
            for (int k = 0; k < N; k++) begin
               g = (rr[o] + k) % N;
               if (gsrc[o] < 0 && fifo_q[g].size() > 0 && int'(fifo_q[g][0] % N) == o) gsrc[o] = g;
            end
         end
         for (int o = 0; o < N; o++) begin
            if (gsrc[o] >= 0) begin
               exp_out[o] = fifo_q[gsrc[o]].pop_front();
               rr[o]      = (gsrc[o] + 1) % N;
            end else begin
               exp_out[o] = '0;
            end
         end
         for (int i = 0; i < N; i++) begin
            f = drv[i*W +: W];
            if (f[W-1]) begin
               if (!was_full[i]) fifo_q[i].push_back(f);
               else if (exp_drop < 65535) exp_drop++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int o = 0; o < N; o++)
            chk($sformatf("out%0d", o), 64'(bus.out_data[o*W +: W]), 64'(exp_out[o]));
         for (int i = 0; i < N; i++)
            chk($sformatf("in_full%0d", i), 64'(bus.in_full[i]), 64'(fifo_q[i].size() == DEPTH));
         chk("drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
      end
   end

   initial begin
      logic [N*W-1:0] v;
      logic [W-1:0]   f;
      int             src;
      rst = 1'b1;
      drv = '0;
      @(negedge clk);
      chk_en = 1'b1;
      chk("reset_out", 64'(bus.out_data), 64'd0);
      chk("reset_full", 64'(bus.in_full), 64'd0);
      chk("reset_drop", 64'(bus.drop_cnt), 64'd0);
      cyc('0);
      rst = 1'b0;

      // Single flit latency
      cyc(put(0, 10'h203));
      cyc('0);
      chk("single_out3", 64'(bus.out_data[3*W +: W]), 64'h203);
      chk("single_others", 64'(bus.out_data[3*W-1:0]), 64'd0);
      chk("single_drop", 64'(bus.drop_cnt), 64'd0);
      idle(4);

      // Contention on output 1, then pointer-order probe
      cyc(put(0, 10'h201) | put(2, 10'h241));
      cyc('0);
      chk("cont_first", 64'(bus.out_data[1*W +: W]), 64'h201);
      cyc('0);
      chk("cont_second", 64'(bus.out_data[1*W +: W]), 64'h241);
      cyc(put(1, 10'h205) | put(3, 10'h209));
      cyc('0);
      chk("rr_ptr3_wins", 64'(bus.out_data[1*W +: W]), 64'h209);
      cyc('0);
      chk("rr_then_in1", 64'(bus.out_data[1*W +: W]), 64'h205);
      idle(4);

      // Fairness: every input streams to output 0
      for (int k = 0; k < 16; k++) exp_q.push_back(W'(k % N));
      for (int c = 0; c < 44; c++) begin
         v = '0;
         if (c < 24)
            for (int i = 0; i < N; i++) v |= put(i, W'(10'h200 | ((c % 32) << 4) | (i << 2)));
         cyc(v);
         if (bus.out_data[W-1] && exp_q.size() > 0) begin
            src = int'(bus.out_data[3:2]);
            chk("fair_src", 64'(src), 64'(exp_q.pop_front()));
         end
      end
      chk("fair_all_seen", 64'(exp_q.size()), 64'd0);
      idle(20);

      // Overflow: in1 streams 7 flits to output 2 against three short bursts
      rst = 1'b1;
      cyc('0);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         v = put(1, W'(10'h200 | (k << 4) | (1 << 2) | 2));
         if (k < 4) begin
            v |= put(0, W'(10'h200 | (k << 4) | (0 << 2) | 2));
            v |= put(2, W'(10'h200 | (k << 4) | (2 << 2) | 2));
            v |= put(3, W'(10'h200 | (k << 4) | (3 << 2) | 2));
         end
         cyc(v);
         if (k == 4) chk("ovf_full1", 64'(bus.in_full), 64'b0010);
      end
      chk("ovf_drop", 64'(bus.drop_cnt), 64'd2);
      chk("ovf_full1_clear", 64'(bus.in_full[1]), 64'd0);
      idle(30);

      // Parallel: a permutation moves in one cycle
      cyc(put(0, 10'h281) | put(1, 10'h2C0) | put(2, 10'h223) | put(3, 10'h2A2));
      cyc('0);
      chk("parallel", 64'(bus.out_data),
          64'(put(0, 10'h2C0) | put(1, 10'h281) | put(2, 10'h2A2) | put(3, 10'h223)));
      idle(5);

      // Reset mid-stream discards buffered flits and ignores reset-cycle input
      v = '0;
      for (int i = 0; i < N; i++) v |= put(i, W'(10'h210 | (i << 2)));
      cyc(v);
      cyc('0);
      rst = 1'b1;
      cyc(put(0, 10'h203));
      rst = 1'b0;
      chk("mid_rst_out", 64'(bus.out_data), 64'd0);
      chk("mid_rst_full", 64'(bus.in_full), 64'd0);
      chk("mid_rst_drop", 64'(bus.drop_cnt), 64'd0);
      cyc(put(2, 10'h211));
      cyc('0);
      chk("post_rst_latency", 64'(bus.out_data), 64'(put(1, 10'h211)));
      for (int c = 0; c < 6; c++) begin
         cyc('0);
         chk("post_rst_quiet", 64'(bus.out_data), 64'd0);
      end

      // Random traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         v = '0;
         for (int i = 0; i < N; i++) begin
            f = W'($urandom);
            f[W-1] = ($urandom_range(0, 1) == 1);
            v |= put(i, f);
         end
         rst = ($urandom_range(0, 499) == 0);
         cyc(v);
      end
      rst = 1'b0;
      idle(20);

      // Saturation: three drops per cycle push the counter past its ceiling
      rst = 1'b1;
      cyc('0);
      rst = 1'b0;
      for (int c = 0; c < 22000; c++) begin
         v = '0;
         for (int i = 0; i < N; i++) v |= put(i, W'(10'h200 | (($urandom_range(0, 31)) << 4) | (i << 2)));
         cyc(v);
      end
      chk("drop_saturated", 64'(bus.drop_cnt), 64'hFFFF);
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
